// File: rtl/binary_to_bcd.sv
// Iterative double-dabble binary to 4-digit packed BCD converter.
// Optional: define BCD_BLANK_LEADING_EN to blank leading zeros as 4'hF.
module binary_to_bcd #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] binary,
  output logic             busy,
  output logic             done,
  output logic [3:0]       thousands,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  localparam int SW = 16 + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     dig_q, dig_d;
  logic            done_q, done_d;

  logic [15:0]     bcd_f;
  logic [15:0]     bcd_adj;
  logic [SW-1:0]   sr_shift;
  logic [15:0]     dig_out;

  always_comb begin
    bcd_f = sr_q[SW-1 -: 16];
    bcd_adj = bcd_f;
    for (int i = 0; i < 4; i++) begin
      if (bcd_f[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_f[4*i +: 4] + 4'd3;
    end
    sr_shift = {bcd_adj, sr_q[WIDTH-1:0]} << 1;
  end

  always_comb begin
    dig_out = bcd_f;
`ifdef BCD_BLANK_LEADING_EN
    // ones is never blanked, so a zero value still shows a single 0
    if (bcd_f[15:12] == 4'd0) begin
      dig_out[15:12] = 4'hF;
      if (bcd_f[11:8] == 4'd0) begin
        dig_out[11:8] = 4'hF;
        if (bcd_f[7:4] == 4'd0)
          dig_out[7:4] = 4'hF;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = {16'd0, binary};
          cnt_d   = CW'(WIDTH);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        if (cnt_q != '0) begin
          sr_d  = sr_shift;
          cnt_d = cnt_q - CW'(1);
        end else begin
          dig_d   = dig_out;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == S_CONV);
  assign done      = done_q;
  assign thousands = dig_q[15:12];
  assign hundreds  = dig_q[11:8];
  assign tens      = dig_q[7:4];
  assign ones      = dig_q[3:0];

endmodule

// File: tb/tb_binary_to_bcd.sv
// Scoreboard bench for binary_to_bcd: digits, latency, busy width.
module tb_binary_to_bcd;

  localparam int WIDTH = 10;
  localparam int LAT = WIDTH + 1;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] binary;
  logic             busy;
  logic             done;
  logic [3:0]       thousands;
  logic [3:0]       hundreds;
  logic [3:0]       tens;
  logic [3:0]       ones;

  int pass_cnt;
  int total_cnt;
  int cyc;
  int busy_run;

  typedef struct {
    logic [15:0] dig;
    int          acc;
  } exp_t;

  exp_t sb_q[$];

  binary_to_bcd #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .binary    (binary),
    .busy      (busy),
    .done      (done),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] blk(input logic [15:0] b);
    logic [15:0] r;
    r = b;
`ifdef BCD_BLANK_LEADING_EN
    if (b[15:12] == 4'd0) begin
      r[15:12] = 4'hF;
      if (b[11:8] == 4'd0) begin
        r[11:8] = 4'hF;
        if (b[7:4] == 4'd0) r[7:4] = 4'hF;
      end
    end
`endif
    return r;
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!reset) begin
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else if (done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", int'(done), 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("digits", int'({thousands, hundreds, tens, ones}),
              int'(e.dig));
        check("latency", cyc - e.acc, LAT);
        check("busy_cycles", busy_run, LAT);
      end
      busy_run = 0;
    end
  end

  task automatic do_conv(input int v, input logic [15:0] hand);
    exp_t e;
    start  = 1'b1;
    binary = WIDTH'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    e.dig = blk(hand);
    e.acc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    busy_run  = 0;
    reset  = 1'b0;
    start  = 1'b0;
    binary = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_digits", int'({thousands, hundreds, tens, ones}), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    do_conv(0, 16'h0000);    wait_done();
    do_conv(1, 16'h0001);    wait_done();
    do_conv(5, 16'h0005);    wait_done();
    do_conv(9, 16'h0009);    wait_done();
    do_conv(12, 16'h0012);   wait_done();
    do_conv(45, 16'h0045);   wait_done();
    do_conv(359, 16'h0359);  wait_done();
    do_conv(1023, 16'h1023); wait_done();
    do_conv(999, 16'h0999);  wait_done();

    // Abort at edge 5 of a conversion
    do_conv(359, 16'h0359);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    void'(sb_q.pop_back());
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_digits", int'({thousands, hundreds, tens, ones}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    do_conv(359, 16'h0359);  wait_done();

    // start while busy is ignored, binary changes have no effect
    repeat (2) @(posedge clk);
    #1;
    do_conv(359, 16'h0359);
    repeat (3) @(posedge clk);
    #1;
    start  = 1'b1;
    binary = WIDTH'(45);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    // start in the done cycle is accepted
    do_conv(45, 16'h0045);   wait_done();

    repeat (20) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd.md
Name: binary_to_bcd

Overview:
Sequential binary-to-BCD converter using iterative double-dabble (shift-and-add-3). It converts a WIDTH-bit unsigned switch value into four packed BCD digits (thousands, hundreds, tens, ones) for the seven-segment display path. A start/busy/done handshake drives it, and the digit outputs are registered and held between conversions.

Parameters:
WIDTH, 10, bit width of the binary input; legal range 1..13, so the maximum value 8191 fits in four digits.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted); released synchronously by the system.
start  input  1  request a conversion of binary; sampled on the rising edge.
binary  input  WIDTH  unsigned value to convert; captured on the accepting edge only.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when the digit outputs update.
thousands  output  4  BCD thousands digit.
hundreds  output  4  BCD hundreds digit.
tens  output  4  BCD tens digit.
ones  output  4  BCD ones digit.

Behaviour:
- Reset (reset=0, asynchronous): busy=0, done=0, all four digits=0, internal shift register and counter cleared. Reset during a conversion aborts it; no done pulse is issued.
- Idle: busy=0. A start=1 seen on an edge with busy=0 is accepted. That edge is edge 0.
- Edge 0: binary is loaded into the low WIDTH bits of a (16+WIDTH)-bit scratch register; the BCD field is cleared; the iteration counter is set to WIDTH; busy goes to 1.
- Edges 1..WIDTH, one iteration per edge: every BCD nibble >=5 has 3 added, then the whole scratch register shifts left by 1. The add uses nibble values before the shift, and all nibbles are adjusted in parallel.
- Edge WIDTH+1: the BCD field is copied to thousands/hundreds/tens/ones; done=1 for exactly this cycle; busy=0.
- Latency: digits valid and done high WIDTH+1 edges after the accepting edge. This is 11 edges for WIDTH=10.
- start while busy=1 is ignored; it is not queued. start in the cycle where done=1 is accepted, since busy is already 0 then, giving back-to-back conversions.
- Changes on binary after the accepting edge do not affect the conversion in progress.
- Digit outputs hold their last value until the next done. Each digit is always in the range 0..9. Unused high digits read 0, for example thousands=0 for any value <1000.
- done is a registered output and never asserts without a preceding accepted start.

Optional Feature:
BCD_BLANK_LEADING_EN
- Defined: when outputs update, each leading zero digit above the lowest non-zero digit is output as 4'hF, which the display decoder treats as blank. ones is never blanked, so a value of 0 gives F,F,F,0 and 45 gives F,F,4,5. Latency is unchanged.
- Not defined: plain BCD; leading zeros are output as 0.

Test Plan:
- Assert reset low mid-conversion (edge 5 after start of 359) -> busy=0, done=0, digits=0 immediately; no done pulse follows; a later start of 359 completes normally.
- Start with binary=0, 1, 5, 9 in sequence, waiting for done each time -> digits 0000, 0001, 0005, 0009; done pulses 11 edges after each start; busy high for 11 cycles.
- binary=12, 45, 359 -> 0012, 0045, 0359; thousands=0 in every case.
- binary=1023 (all ones) and 999 -> 1023 and 0999; verifies the add-3 at every nibble boundary.
- Start 359, then raise start with binary=45 while busy -> result 0359 and only one done pulse. Start 45 in the cycle done=1 -> accepted; 0045 after 11 more edges.
- With BCD_BLANK_LEADING_EN: 0 -> F,F,F,0; 45 -> F,F,4,5; 1023 -> 1,0,2,3.
